hwpe_ctrl_periph_slave_fpga: RTL and testbench
==============================================

Name: hwpe_ctrl_periph_slave_fpga

Overview:
Peripheral-side slave that sits directly upstream of the FPGA control register file. It terminates the HWPE peripheral request/grant/response protocol and drives the register file's read and write ports. It also owns a small control region with trigger, status, soft-clear and completed-job count registers, plus a job FSM that produces start, busy and event signals towards the engine.

Parameters:
ADDR_WIDTH, 5, register file word-address width (2**ADDR_WIDTH words); must match the downstream register file.
DATA_WIDTH, 32, data width; fixed at 32.
ID_WIDTH, 8, width of the request/response transaction ID.
CNT_WIDTH, 16, width of the completed-job counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  1  peripheral request
gnt  out  1  grant
add  in  32  byte address
wen  in  1  1 = read, 0 = write
be  in  4  byte enables
data  in  32  write data
id  in  ID_WIDTH  request ID
r_valid  out  1  response valid
r_data  out  32  read data
r_id  out  ID_WIDTH  response ID
rf_ReadEnable  out  1  to register file
rf_ReadAddr  out  ADDR_WIDTH  to register file
rf_ReadData  in  32  from register file; valid the cycle after rf_ReadEnable
rf_WriteEnable  out  1  to register file
rf_WriteAddr  out  ADDR_WIDTH  to register file
rf_WriteData  out  32  to register file
rf_WriteBE  out  4  to register file
clear_o  out  1  soft-clear pulse to register file and engine
start_o  out  1  job start pulse
done_i  in  1  engine job-done pulse
busy_o  out  1  job running
evt_o  out  1  job-completed event pulse

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous, active-low. All registered outputs are 0 at reset: r_valid, r_data, r_id, clear_o, start_o, busy_o, evt_o. Job FSM resets to IDLE; counter resets to 0.
- Grant: gnt = req combinationally. Every request is accepted in one cycle; there is no back-pressure.
- Decode: word = add[ADDR_WIDTH+1:2]. Select bit S = add[ADDR_WIDTH+2].
  - S=1: register-file region.
  - S=0: control region, word index add[3:2] (0 TRIGGER, 1 STATUS, 2 SOFT_CLEAR, 3 JOB_CNT). Address bits above ADDR_WIDTH+2 are ignored.
- Register-file write: when req & ~wen & S and FSM=IDLE:
  - rf_WriteEnable=1, WriteAddr=word, WriteData=data, WriteBE=be, all combinational in the same cycle.
  - In RUNNING, register-file writes are dropped silently but still granted and acknowledged.
- Register-file read: when req & wen & S, rf_ReadEnable=1 and rf_ReadAddr=word. Otherwise rf_ReadEnable=0 and rf_ReadAddr=0.
- Response, one cycle after every granted request (read or write):
  - r_valid=1 and r_id = the registered id.
  - r_data comes from a registered source select:
    - register-file read: rf_ReadData.
    - STATUS: {31'b0, busy}.
    - JOB_CNT: zero-extended counter.
    - TRIGGER, SOFT_CLEAR and all writes: 0.
  - Back-to-back requests give back-to-back responses.
- Job FSM states: IDLE, RUNNING.
  - IDLE -> RUNNING on a TRIGGER write with any data; start_o pulses for 1 cycle in the cycle after the write.
  - RUNNING -> IDLE on done_i; evt_o pulses for 1 cycle in the cycle after done_i, and the counter increments, wrapping at 2**CNT_WIDTH.
  - busy_o = (state==RUNNING).
  - A TRIGGER write in RUNNING is ignored.
  - done_i in IDLE is ignored.
  - If done_i and a TRIGGER write occur in the same RUNNING cycle, done wins and the trigger is dropped.
- SOFT_CLEAR write:
  - clear_o pulses for 1 cycle in the cycle after the write.
  - FSM is forced to IDLE and the counter to 0 on that same edge.
  - Any pending response is still delivered.
  - If a TRIGGER write arrives in the cycle clear_o is high, it is honoured.
- JOB_CNT is read-only; writes to STATUS or JOB_CNT are acknowledged with no effect.
- Asynchronous reset mid-job: busy_o drops immediately and no evt_o is generated.

Test Plan:
- Write 0xDEADBEEF with be=4'b1111 to the regfile word at byte address 0x84 (ADDR_WIDTH=5) -> rf_WriteEnable=1 with WriteAddr=1 in the same cycle; r_valid=1 with r_data=0 next cycle. A read of the same address then returns 0xDEADBEEF one cycle later with matching r_id=0x5A.
- Write TRIGGER -> start_o pulses 1 cycle later and busy_o=1. A STATUS read returns 1. A regfile write issued while busy leaves the word unchanged on readback.
- done_i pulses 3 times across 3 trigger/done jobs -> evt_o pulses 3 times and JOB_CNT reads 3. With CNT_WIDTH=2, a 4th job wraps JOB_CNT to 0.
- In RUNNING, pulse done_i in the same cycle as a TRIGGER write -> busy_o=0 next cycle and no start_o.
- SOFT_CLEAR while RUNNING with JOB_CNT=2 -> clear_o pulses, busy_o=0, JOB_CNT reads 0.
- Issue 4 back-to-back reads with ids 1..4 -> r_valid stays high for 4 consecutive cycles with r_id 1,2,3,4 in order. Assert rst_n=0 mid-job -> busy_o and r_valid go to 0 asynchronously.

Source files
------------

// File: rtl/hwpe_ctrl_periph_slave_fpga.sv
// Peripheral slave in front of the FPGA control register file: terminates the
// req/gnt/r_valid protocol, drives the register-file ports and runs the job FSM.
module hwpe_ctrl_periph_slave_fpga #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req,
   output logic                    gnt,
   input  logic [31:0]             add,
   input  logic                    wen,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic [ID_WIDTH-1:0]     id,
   output logic                    r_valid,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [ID_WIDTH-1:0]     r_id,
   output logic                    rf_ReadEnable,
   output logic [ADDR_WIDTH-1:0]   rf_ReadAddr,
   input  logic [DATA_WIDTH-1:0]   rf_ReadData,
   output logic                    rf_WriteEnable,
   output logic [ADDR_WIDTH-1:0]   rf_WriteAddr,
   output logic [DATA_WIDTH-1:0]   rf_WriteData,
   output logic [DATA_WIDTH/8-1:0] rf_WriteBE,
   output logic                    clear_o,
   output logic                    start_o,
   input  logic                    done_i,
   output logic                    busy_o,
   output logic                    evt_o
);

   typedef enum logic {IDLE, RUNNING} state_t;
   typedef enum logic [1:0] {SEL_ZERO, SEL_RF, SEL_STATUS, SEL_CNT} rsel_t;

   localparam logic [1:0] REG_TRIGGER    = 2'd0;
   localparam logic [1:0] REG_STATUS     = 2'd1;
   localparam logic [1:0] REG_SOFT_CLEAR = 2'd2;
   localparam logic [1:0] REG_JOB_CNT    = 2'd3;

   state_t                state_q, state_d;
   rsel_t                 rsel_q, rsel_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  start_d, evt_d, cnt_inc;

   logic                  sel_rf;
   logic [ADDR_WIDTH-1:0] word;
   logic [1:0]            ctrl_idx;
   logic                  wr_req, rd_req, trig_wr, clr_wr;
   logic                  unused_add;

   assign sel_rf   = add[ADDR_WIDTH+2];
   assign word     = add[ADDR_WIDTH+1:2];
   assign ctrl_idx = add[3:2];
   assign unused_add = ^{add[31:ADDR_WIDTH+3], add[1:0]};

   assign gnt     = req;
   assign wr_req  = req & ~wen;
   assign rd_req  = req & wen;
   assign trig_wr = wr_req & ~sel_rf & (ctrl_idx == REG_TRIGGER);
   assign clr_wr  = wr_req & ~sel_rf & (ctrl_idx == REG_SOFT_CLEAR);

   // Register-file writes are blocked while a job runs so the engine sees stable config.
   assign rf_WriteEnable = wr_req & sel_rf & (state_q == IDLE);
   assign rf_WriteAddr   = rf_WriteEnable ? word : '0;
   assign rf_WriteData   = rf_WriteEnable ? data : '0;
   assign rf_WriteBE     = rf_WriteEnable ? be   : '0;
   assign rf_ReadEnable  = rd_req & sel_rf;
   assign rf_ReadAddr    = rf_ReadEnable ? word : '0;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      rsel_d = SEL_ZERO;
      if (rd_req) begin
         if (sel_rf)                         rsel_d = SEL_RF;
         else if (ctrl_idx == REG_STATUS)    rsel_d = SEL_STATUS;
         else if (ctrl_idx == REG_JOB_CNT)   rsel_d = SEL_CNT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_id    <= '0;
         rsel_q  <= SEL_ZERO;
      end else begin
         r_valid <= req;
         rsel_q  <= rsel_d;
         if (req) r_id <= id;
      end
   end

   // Register-file data arrives the cycle after the read, aligned with r_valid.
   always_comb begin
      r_data = '0;
      case (rsel_q)
         SEL_RF:     r_data = rf_ReadData;
         SEL_STATUS: r_data = {{(DATA_WIDTH-1){1'b0}}, busy_o};
         SEL_CNT:    r_data = {{(DATA_WIDTH-CNT_WIDTH){1'b0}}, cnt_q};
         default:    r_data = '0;
      endcase
   end

   // Job FSM: state register, pulse registers and completed-job counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         start_o <= 1'b0;
         evt_o   <= 1'b0;
         clear_o <= 1'b0;
      end else begin
         state_q <= state_d;
         start_o <= start_d;
         evt_o   <= evt_d;
         clear_o <= clr_wr;
         if (clr_wr)       cnt_q <= '0;
         else if (cnt_inc) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   // Soft clear overrides everything; done beats a simultaneous trigger.
   always_comb begin
      state_d = state_q;
      if (clr_wr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (trig_wr) state_d = RUNNING;
            RUNNING: if (done_i)  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      start_d = (state_q == IDLE) & trig_wr;
      evt_d   = (state_q == RUNNING) & done_i & ~clr_wr;
      cnt_inc = evt_d;
      busy_o  = (state_q == RUNNING);
   end

endmodule

// File: tb/tb_hwpe_ctrl_periph_slave_fpga.sv
// Self-checking bench: directed table, back-to-back and reset sequences, then
// random traffic compared against a transaction-level reference model.
module tb_hwpe_ctrl_periph_slave_fpga;

   localparam int AW = 5;
   localparam int IW = 8;
   localparam int CW = 2;

   logic          clk, rst_n;
   logic          req, gnt, wen, r_valid, done_i;
   logic [31:0]   add, data, r_data;
   logic [3:0]    be;
   logic [IW-1:0] id, r_id;
   logic          rf_ReadEnable, rf_WriteEnable;
   logic [AW-1:0] rf_ReadAddr, rf_WriteAddr;
   logic [31:0]   rf_ReadData, rf_WriteData;
   logic [3:0]    rf_WriteBE;
   logic          clear_o, start_o, busy_o, evt_o;

   int checks   = 0;
   int failures = 0;

   hwpe_ctrl_periph_slave_fpga #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ID_WIDTH(IW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .add(add), .wen(wen),
      .be(be), .data(data), .id(id), .r_valid(r_valid), .r_data(r_data), .r_id(r_id),
      .rf_ReadEnable(rf_ReadEnable), .rf_ReadAddr(rf_ReadAddr), .rf_ReadData(rf_ReadData),
      .rf_WriteEnable(rf_WriteEnable), .rf_WriteAddr(rf_WriteAddr),
      .rf_WriteData(rf_WriteData), .rf_WriteBE(rf_WriteBE),
      .clear_o(clear_o), .start_o(start_o), .done_i(done_i), .busy_o(busy_o), .evt_o(evt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream register file: byte-enabled writes, one-cycle read latency.
   logic [31:0] rf_mem [32];
   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      rf_ReadData = '0;
   end
   always @(posedge clk) begin
      if (rf_WriteEnable)
         for (int k = 0; k < 4; k++)
            if (rf_WriteBE[k]) rf_mem[rf_WriteAddr][8*k +: 8] <= rf_WriteData[8*k +: 8];
      if (rf_ReadEnable) rf_ReadData <= rf_mem[rf_ReadAddr];
   end

   // Reference model state.
   logic [31:0] m_mem [32];
   bit          m_busy;
   int          m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input logic rq, input logic wn, input logic [31:0] ad,
                       input logic [3:0] b, input logic [31:0] d, input logic [IW-1:0] i,
                       input logic dn);
      logic s, exp_we, exp_re, trig, clr, e_start, e_evt;
      logic [4:0] w;
      logic [1:0] x;
      logic [31:0] exp_rd;
      @(negedge clk);
      req = rq; wen = wn; add = ad; be = b; data = d; id = i; done_i = dn;
      s = ad[7]; w = ad[6:2]; x = ad[3:2];
      exp_we = rq & ~wn & s & ~m_busy;
      exp_re = rq & wn & s;
      #1;
      check("gnt", gnt, rq);
      check("rf_we", rf_WriteEnable, exp_we);
      if (exp_we) begin
         check("rf_waddr", rf_WriteAddr, w);
         check("rf_wdata", rf_WriteData, d);
         check("rf_wbe", rf_WriteBE, b);
      end
      check("rf_re", rf_ReadEnable, exp_re);
      check("rf_raddr", rf_ReadAddr, exp_re ? w : 5'd0);

      trig = rq & ~wn & ~s & (x == 2'd0);
      clr  = rq & ~wn & ~s & (x == 2'd2);
      e_start = 1'b0; e_evt = 1'b0;
      exp_rd = exp_re ? m_mem[w] : 32'd0;
      if (exp_we)
         for (int k = 0; k < 4; k++)
            if (b[k]) m_mem[w][8*k +: 8] = d[8*k +: 8];
      if (clr) begin
         m_busy = 1'b0; m_cnt = 0;
      end else if (m_busy && dn) begin
         m_busy = 1'b0; m_cnt = (m_cnt + 1) % (1 << CW); e_evt = 1'b1;
      end else if (!m_busy && trig) begin
         m_busy = 1'b1; e_start = 1'b1;
      end
      if (rq & wn & ~s & (x == 2'd1)) exp_rd = {31'd0, m_busy};
      if (rq & wn & ~s & (x == 2'd3)) exp_rd = m_cnt;

      @(posedge clk);
      #1;
      check("r_valid", r_valid, rq);
      if (rq) begin
         check("r_id", r_id, i);
         check("r_data", r_data, exp_rd);
      end
      check("busy_o", busy_o, m_busy);
      check("start_o", start_o, e_start);
      check("evt_o", evt_o, e_evt);
      check("clear_o", clear_o, clr);
   endtask

   typedef struct {
      logic        req, wen;
      logic [31:0] add;
      logic [3:0]  be;
      logic [31:0] data;
      logic [7:0]  id;
      logic        done;
      logic [31:0] exp_rdata;
      logic        exp_busy, exp_start, exp_evt, exp_clear;
   } vec_t;

   function automatic vec_t mk(logic rq, logic wn, logic [31:0] ad, logic [3:0] b,
                               logic [31:0] d, logic [7:0] i, logic dn, logic [31:0] rd,
                               logic bz, logic st, logic ev, logic cl);
      vec_t v;
      v.req = rq; v.wen = wn; v.add = ad; v.be = b; v.data = d; v.id = i; v.done = dn;
      v.exp_rdata = rd; v.exp_busy = bz; v.exp_start = st; v.exp_evt = ev; v.exp_clear = cl;
      return v;
   endfunction

   vec_t tbl [31];

   initial begin
      logic [31:0] a;
      logic        rq, wn, dn;

      tbl[0]  = mk(1,0,32'h84, 4'hF,32'hDEADBEEF,8'h11,0, 32'h0,        0,0,0,0);
      tbl[1]  = mk(1,1,32'h84, 4'h0,32'h0,       8'h5A,0, 32'hDEADBEEF, 0,0,0,0);
      tbl[2]  = mk(1,0,32'h00, 4'hF,32'h0,       8'h20,0, 32'h0,        1,1,0,0);
      tbl[3]  = mk(1,1,32'h04, 4'h0,32'h0,       8'h21,0, 32'h1,        1,0,0,0);
      tbl[4]  = mk(1,0,32'h84, 4'hF,32'h12345678,8'h22,0, 32'h0,        1,0,0,0);
      tbl[5]  = mk(1,1,32'h84, 4'h0,32'h0,       8'h23,0, 32'hDEADBEEF, 1,0,0,0);
      tbl[6]  = mk(0,0,32'h00, 4'h0,32'h0,       8'h00,1, 32'h0,        0,0,1,0);
      tbl[7]  = mk(1,1,32'h0C, 4'h0,32'h0,       8'h24,0, 32'h1,        0,0,0,0);
      tbl[8]  = mk(1,0,32'h00, 4'hF,32'h7,       8'h25,0, 32'h0,        1,1,0,0);
      tbl[9]  = mk(0,0,32'h00, 4'h0,32'h0,       8'h00,1, 32'h0,        0,0,1,0);
      tbl[10] = mk(1,0,32'h00, 4'hF,32'h0,       8'h26,0, 32'h0,        1,1,0,0);
      tbl[11] = mk(0,0,32'h00, 4'h0,32'h0,       8'h00,1, 32'h0,        0,0,1,0);
      tbl[12] = mk(1,1,32'h0C, 4'h0,32'h0,       8'h27,0, 32'h3,        0,0,0,0);
      tbl[13] = mk(1,0,32'h00, 4'hF,32'h0,       8'h28,0, 32'h0,        1,1,0,0);
      tbl[14] = mk(0,0,32'h00, 4'h0,32'h0,       8'h00,1, 32'h0,        0,0,1,0);
      tbl[15] = mk(1,1,32'h0C, 4'h0,32'h0,       8'h29,0, 32'h0,        0,0,0,0);
      tbl[16] = mk(1,0,32'h00, 4'hF,32'h0,       8'h2A,0, 32'h0,        1,1,0,0);
      tbl[17] = mk(1,0,32'h00, 4'hF,32'h0,       8'h2B,1, 32'h0,        0,0,1,0);
      tbl[18] = mk(1,0,32'h00, 4'hF,32'h0,       8'h2C,0, 32'h0,        1,1,0,0);
      tbl[19] = mk(0,0,32'h00, 4'h0,32'h0,       8'h00,1, 32'h0,        0,0,1,0);
      tbl[20] = mk(1,0,32'h00, 4'hF,32'h0,       8'h2D,0, 32'h0,        1,1,0,0);
      tbl[21] = mk(1,0,32'h08, 4'hF,32'h0,       8'h2E,0, 32'h0,        0,0,0,1);
      tbl[22] = mk(1,0,32'h00, 4'hF,32'h0,       8'h2F,0, 32'h0,        1,1,0,0);
      tbl[23] = mk(1,1,32'h0C, 4'h0,32'h0,       8'h30,0, 32'h0,        1,0,0,0);
      tbl[24] = mk(0,0,32'h00, 4'h0,32'h0,       8'h00,1, 32'h0,        0,0,1,0);
      tbl[25] = mk(1,0,32'h88, 4'h5,32'hAABBCCDD,8'h31,0, 32'h0,        0,0,0,0);
      tbl[26] = mk(1,1,32'h88, 4'h0,32'h0,       8'h32,0, 32'h00BB00DD, 0,0,0,0);
      tbl[27] = mk(1,1,32'hF84,4'h0,32'h0,       8'h33,0, 32'hDEADBEEF, 0,0,0,0);
      tbl[28] = mk(1,0,32'h04, 4'hF,32'hFFFFFFFF,8'h34,0, 32'h0,        0,0,0,0);
      tbl[29] = mk(1,0,32'h0C, 4'hF,32'hFFFFFFFF,8'h35,0, 32'h0,        0,0,0,0);
      tbl[30] = mk(1,1,32'h0C, 4'h0,32'h0,       8'h36,0, 32'h1,        0,0,0,0);

      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = 1'b0; m_cnt = 0;
      rst_n = 1'b0; req = 1'b0; wen = 1'b0; add = '0; be = '0; data = '0; id = '0; done_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_r_valid", r_valid, 0);
      check("rst_r_data", r_data, 0);
      check("rst_r_id", r_id, 0);
      check("rst_clear", clear_o, 0);
      check("rst_start", start_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_evt", evt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[n]) begin
         step(tbl[n].req, tbl[n].wen, tbl[n].add, tbl[n].be, tbl[n].data, tbl[n].id, tbl[n].done);
         if (tbl[n].req) check($sformatf("tbl%0d_rdata", n), r_data, tbl[n].exp_rdata);
         check($sformatf("tbl%0d_busy", n), busy_o, tbl[n].exp_busy);
         check($sformatf("tbl%0d_start", n), start_o, tbl[n].exp_start);
         check($sformatf("tbl%0d_evt", n), evt_o, tbl[n].exp_evt);
         check($sformatf("tbl%0d_clear", n), clear_o, tbl[n].exp_clear);
      end

      // Back-to-back reads: responses must stream with ids in order.
      for (int n = 1; n <= 4; n++) begin
         step(1, 1, 32'h84, 4'h0, 32'h0, IW'(n), 0);
         check($sformatf("b2b_valid%0d", n), r_valid, 1);
         check($sformatf("b2b_id%0d", n), r_id, n);
         check($sformatf("b2b_data%0d", n), r_data, 32'hDEADBEEF);
      end

      // Asynchronous reset mid-job and mid-response.
      step(1, 0, 32'h00, 4'hF, 32'h0, 8'h40, 0);
      step(1, 1, 32'h84, 4'h0, 32'h0, 8'h41, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_r_valid", r_valid, 0);
      check("arst_evt", evt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_busy = 1'b0; m_cnt = 0;
      step(0, 0, 32'h0, 4'h0, 32'h0, 8'h0, 1);
      check("arst_no_evt", evt_o, 0);

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         rq = ($urandom_range(0, 4) != 0);
         wn = $urandom_range(0, 1);
         a  = $urandom();
         a[7] = ($urandom_range(0, 2) != 0);
         if (!a[7] && !wn && a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) a[3:2] = 2'd0;
         dn = ($urandom_range(0, 5) == 0);
         step(rq, wn, a, 4'($urandom()), $urandom(), IW'($urandom()), dn);
      end

      step(0, 0, 32'h0, 4'h0, 32'h0, 8'h0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
